pipe_front_ctrl: RTL and testbench
==================================

PIPE_FRONT_CTRL -- requirements
Module: pipe_front_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 4: consecutive stall cycles at which o_deadlock sets.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have ports i_pc_en, i_IF_ID_stall, i_ID_EX_flush, inputs, 1 each, stall/flush requests from the hazard detector.
REQ-005 SHALL have port i_br_taken, input, 1, EX-stage taken branch or jump redirect.
REQ-006 SHALL have ports i_IF_pc and i_IF_inst, inputs, 32 each, fetched PC and instruction.
REQ-007 SHALL have port i_ID_rd_wren, input, 1, decoded rd write enable of the ID instruction.
REQ-008 SHALL have ports o_ID_pc and o_ID_inst, outputs, 32 each, plus o_ID_valid, output, 1: the IF/ID register.
REQ-009 SHALL have ports o_EX_pc and o_EX_inst, outputs, 32 each, plus o_EX_rd_wren and o_EX_valid, outputs, 1 each: the ID/EX register.
REQ-010 SHALL have ports o_pc_en and o_pc_sel, outputs, 1 each: PC write enable and redirect select.
REQ-011 SHALL have ports o_state, output, 2, FSM state, and o_deadlock, output, 1, sticky stall watchdog flag.
REQ-012 SHALL have port o_bubble_cnt, output, 32, count of ID/EX bubbles.

Function
REQ-013 IF/ID update priority SHALL be: i_br_taken loads NOP with valid 0; else i_IF_ID_stall holds; else loads i_IF_pc and i_IF_inst with valid 1.
REQ-014 ID/EX update priority SHALL be: i_br_taken or i_ID_EX_flush loads pc 0, NOP, rd_wren 0, valid 0; else loads o_ID_pc, o_ID_inst, i_ID_rd_wren, o_ID_valid.
REQ-015 o_pc_en SHALL equal i_pc_en OR i_br_taken, and o_pc_sel SHALL equal i_br_taken, combinationally, so a redirect is never blocked by a stall.
REQ-016 The FSM SHALL have states RUN=0, STALL=1 and REDIRECT=2; i_br_taken SHALL go to REDIRECT from any state; else i_IF_ID_stall SHALL go to STALL; else the next state SHALL be RUN.
REQ-017 REDIRECT SHALL last exactly one cycle unless i_br_taken is re-asserted.
REQ-018 The consecutive-stall counter SHALL increment in STALL, clear on leaving STALL, and saturate at STALL_LIMIT.
REQ-019 o_deadlock SHALL set in the cycle the counter reaches STALL_LIMIT and stay set until reset.
REQ-020 Simultaneous i_br_taken and hazard stall SHALL resolve as redirect: both registers are bubbled and the PC is written.
REQ-021 Pipeline register latency SHALL be exactly one cycle; outputs SHALL be registered except o_pc_en and o_pc_sel.

Reset
REQ-022 When i_reset is high at a clock edge, all pc fields SHALL become 0, inst fields NOP (32'h0000_0013), and the valid, rd_wren and deadlock flags 0.
REQ-023 Reset SHALL also return the FSM to RUN and clear the stall counter and o_bubble_cnt.
REQ-024 Reset SHALL take priority over i_br_taken and all stall or flush inputs, including mid-stall.

Configuration
REQ-025 With PIPE_PERF_CNT_EN defined, o_bubble_cnt SHALL increment each cycle ID/EX loads a bubble and saturate at 32'hFFFF_FFFF.
REQ-026 Without PIPE_PERF_CNT_EN, o_bubble_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Structure
REQ-027 The NOP constant, the state enum type (RUN, STALL, REDIRECT) and the 32-bit width constant SHALL live in shared package pipe_pkg.
REQ-028 A sub-module pipe_reg SHALL implement one generic stall/flush register (hold, flush-to-default, load) and be instantiated for IF/ID and ID/EX.

Verification
REQ-029 Reset then 3 cycles of free-running fetch at pc 0x0, 0x4, 0x8 -> o_EX_pc = 0x0 at cycle 2 with o_EX_valid=1; o_bubble_cnt=0.
REQ-030 Stall plus flush asserted 2 cycles -> o_ID_inst held, 2 NOPs in EX, o_pc_en=0, o_state=STALL, o_bubble_cnt=2 with the macro.
REQ-031 i_br_taken together with stall -> o_pc_en=1, o_pc_sel=1; next cycle both valids 0, o_state=REDIRECT, then RUN.
REQ-032 Stall held 5 cycles with STALL_LIMIT=4 -> o_deadlock=1 from the 4th stall cycle, still 1 after the stall drops.
REQ-033 i_reset asserted mid-stall -> next cycle all outputs at reset values and o_state=RUN.
REQ-034 Build without PIPE_PERF_CNT_EN and repeat REQ-030 -> o_bubble_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipeline front-end controller.
// Holds the datapath width, the NOP encoding used for bubbles and the
// front-end FSM state type, so every file agrees on them.
package pipe_pkg;

    // Datapath width for PC and instruction fields
    localparam int XLEN = 32;

    // Canonical NOP (addi x0, x0, 0) injected whenever a stage is bubbled
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    // Front-end FSM states; encodings are visible on o_state
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } pipe_state_e;

    // Saturating increment for 32-bit event counters
    function automatic logic [XLEN-1:0] sat_inc32(input logic [XLEN-1:0] value);
        if (value == {XLEN{1'b1}}) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: one generic pipeline register with hold and flush control.
// Reset and flush both load i_default (the bubble pattern); hold keeps the
// current contents; otherwise the register loads i_d every cycle.
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hold,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_default,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Reset beats flush, flush beats hold, hold beats load
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= i_default;
        end else if (i_flush) begin
            r_q <= i_default;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_front_ctrl.sv
// pipe_front_ctrl: IF/ID and ID/EX pipeline registers plus the front-end
// control FSM (RUN / STALL / REDIRECT), a stall watchdog and PC control.
// A taken branch always wins over hazard stalls: both registers are bubbled
// and the PC is written even when the hazard detector holds it.
// Optional feature: define PIPE_PERF_CNT_EN to build the saturating ID/EX
// bubble counter; otherwise o_bubble_cnt is tied to zero.
module pipe_front_ctrl
    import pipe_pkg::*;
#(
    parameter int STALL_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pc_en,
    input  logic        i_IF_ID_stall,
    input  logic        i_ID_EX_flush,
    input  logic        i_br_taken,
    input  logic [31:0] i_IF_pc,
    input  logic [31:0] i_IF_inst,
    input  logic        i_ID_rd_wren,
    output logic [31:0] o_ID_pc,
    output logic [31:0] o_ID_inst,
    output logic        o_ID_valid,
    output logic [31:0] o_EX_pc,
    output logic [31:0] o_EX_inst,
    output logic        o_EX_rd_wren,
    output logic        o_EX_valid,
    output logic        o_pc_en,
    output logic        o_pc_sel,
    output logic [1:0]  o_state,
    output logic        o_deadlock,
    output logic [31:0] o_bubble_cnt
);

    localparam int IFID_W = 2 * XLEN + 1;
    localparam int IDEX_W = 2 * XLEN + 2;
    localparam int CNT_W  = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STALL_LIMIT);

    logic [IFID_W-1:0] w_ifid_d;
    logic [IFID_W-1:0] w_ifid_default;
    logic [IFID_W-1:0] w_ifid_q;
    logic [IDEX_W-1:0] w_idex_d;
    logic [IDEX_W-1:0] w_idex_default;
    logic [IDEX_W-1:0] w_idex_q;
    logic              w_ex_bubble;

    pipe_state_e       r_state;
    pipe_state_e       w_next_state;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  w_stall_cnt_next;
    logic              r_deadlock;

    // ID/EX is bubbled by a redirect as well as by an explicit hazard flush
    assign w_ex_bubble = i_br_taken | i_ID_EX_flush;

    // IF/ID: a redirect squashes the fetched instruction, a stall holds it
    assign w_ifid_d       = {i_IF_pc, i_IF_inst, 1'b1};
    assign w_ifid_default = {{XLEN{1'b0}}, NOP, 1'b0};

    pipe_reg #(
        .WIDTH (IFID_W)
    ) u_if_id (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_hold    (i_IF_ID_stall),
        .i_flush   (i_br_taken),
        .i_d       (w_ifid_d),
        .i_default (w_ifid_default),
        .o_q       (w_ifid_q)
    );

    assign {o_ID_pc, o_ID_inst, o_ID_valid} = w_ifid_q;

    // ID/EX: never holds; either advances the ID contents or takes a bubble
    assign w_idex_d       = {o_ID_pc, o_ID_inst, i_ID_rd_wren, o_ID_valid};
    assign w_idex_default = {{XLEN{1'b0}}, NOP, 1'b0, 1'b0};

    pipe_reg #(
        .WIDTH (IDEX_W)
    ) u_id_ex (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_hold    (1'b0),
        .i_flush   (w_ex_bubble),
        .i_d       (w_idex_d),
        .i_default (w_idex_default),
        .o_q       (w_idex_q)
    );

    assign {o_EX_pc, o_EX_inst, o_EX_rd_wren, o_EX_valid} = w_idex_q;

    // PC control is combinational so a redirect cannot be blocked by a stall
    assign o_pc_en  = i_pc_en | i_br_taken;
    assign o_pc_sel = i_br_taken;

    // Next-state logic: redirect from anywhere, then stall, else run
    always_comb begin
        w_next_state = RUN;
        if (i_br_taken) begin
            w_next_state = REDIRECT;
        end else if (i_IF_ID_stall) begin
            w_next_state = STALL;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign o_state = r_state;

    // Consecutive-stall count: counts cycles spent in STALL, saturating
    always_comb begin
        w_stall_cnt_next = '0;
        if (w_next_state == STALL) begin
            if (r_stall_cnt == LIMIT_C) begin
                w_stall_cnt_next = LIMIT_C;
            end else begin
                w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Stall counter register and sticky watchdog flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_deadlock  <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_next;
            if (w_stall_cnt_next == LIMIT_C) begin
                r_deadlock <= 1'b1;
            end
        end
    end

    assign o_deadlock = r_deadlock;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Counts every cycle in which ID/EX loads a bubble, saturating at all ones
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bubble_cnt <= '0;
        end else if (w_ex_bubble) begin
            r_bubble_cnt <= sat_inc32(r_bubble_cnt);
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
`else
    assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// tb_pipe_front_ctrl: directed and short random stimulus for pipe_front_ctrl.
// Each step pushes the expected register contents onto a scoreboard queue
// from a small reference model; the entry is popped after the clock edge.
module tb_pipe_front_ctrl;

    localparam int          LIMIT  = 4;
    localparam logic [31:0] NOP_TB = 32'h0000_0013;

    logic        i_clk;
    logic        i_reset;
    logic        i_pc_en;
    logic        i_IF_ID_stall;
    logic        i_ID_EX_flush;
    logic        i_br_taken;
    logic [31:0] i_IF_pc;
    logic [31:0] i_IF_inst;
    logic        i_ID_rd_wren;
    logic [31:0] o_ID_pc;
    logic [31:0] o_ID_inst;
    logic        o_ID_valid;
    logic [31:0] o_EX_pc;
    logic [31:0] o_EX_inst;
    logic        o_EX_rd_wren;
    logic        o_EX_valid;
    logic        o_pc_en;
    logic        o_pc_sel;
    logic [1:0]  o_state;
    logic        o_deadlock;
    logic [31:0] o_bubble_cnt;

    typedef struct {
        logic [31:0] idPc;
        logic [31:0] idInst;
        logic        idValid;
        logic [31:0] exPc;
        logic [31:0] exInst;
        logic        exRdWren;
        logic        exValid;
        logic [1:0]  state;
        logic        deadlock;
        logic [31:0] bubble;
    } expT;

    expT expQ[$];

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    logic [31:0] mIdPc, mIdInst, mExPc, mExInst, mBub;
    logic        mIdValid, mExRdWren, mExValid, mDead;
    logic [1:0]  mState;
    int          mCnt;

    pipe_front_ctrl #(
        .STALL_LIMIT (LIMIT)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_pc_en       (i_pc_en),
        .i_IF_ID_stall (i_IF_ID_stall),
        .i_ID_EX_flush (i_ID_EX_flush),
        .i_br_taken    (i_br_taken),
        .i_IF_pc       (i_IF_pc),
        .i_IF_inst     (i_IF_inst),
        .i_ID_rd_wren  (i_ID_rd_wren),
        .o_ID_pc       (o_ID_pc),
        .o_ID_inst     (o_ID_inst),
        .o_ID_valid    (o_ID_valid),
        .o_EX_pc       (o_EX_pc),
        .o_EX_inst     (o_EX_inst),
        .o_EX_rd_wren  (o_EX_rd_wren),
        .o_EX_valid    (o_EX_valid),
        .o_pc_en       (o_pc_en),
        .o_pc_sel      (o_pc_sel),
        .o_state       (o_state),
        .o_deadlock    (o_deadlock),
        .o_bubble_cnt  (o_bubble_cnt)
    );

    // Free-running clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit expired");
    end

    // One comparison: counts it and reports a mismatch
    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Pops the oldest scoreboard entry and compares all registered outputs
    task automatic checkOutput(input string tag);
        expT e;
        if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $error("[TB] FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = expQ.pop_front();
            checkField({tag, ".ID_pc"},    o_ID_pc,      e.idPc);
            checkField({tag, ".ID_inst"},  o_ID_inst,    e.idInst);
            checkField({tag, ".ID_valid"}, o_ID_valid,   e.idValid);
            checkField({tag, ".EX_pc"},    o_EX_pc,      e.exPc);
            checkField({tag, ".EX_inst"},  o_EX_inst,    e.exInst);
            checkField({tag, ".EX_rd"},    o_EX_rd_wren, e.exRdWren);
            checkField({tag, ".EX_valid"}, o_EX_valid,   e.exValid);
            checkField({tag, ".state"},    o_state,      e.state);
            checkField({tag, ".deadlock"}, o_deadlock,   e.deadlock);
            checkField({tag, ".bubble"},   o_bubble_cnt, e.bubble);
        end
    endtask

    // Drives one cycle, checks PC control, models the edge, then checks registers
    task automatic applyStimulus(input string tag, input logic rst, input logic pcEn,
                                 input logic stall, input logic flush, input logic br,
                                 input logic [31:0] pc, input logic [31:0] inst,
                                 input logic rdWren);
        expT e;
        i_reset       = rst;
        i_pc_en       = pcEn;
        i_IF_ID_stall = stall;
        i_ID_EX_flush = flush;
        i_br_taken    = br;
        i_IF_pc       = pc;
        i_IF_inst     = inst;
        i_ID_rd_wren  = rdWren;
        #1;
        checkField({tag, ".pc_en"},  o_pc_en,  pcEn | br);
        checkField({tag, ".pc_sel"}, o_pc_sel, br);

        if (rst) begin
            mIdPc = 0; mIdInst = NOP_TB; mIdValid = 0;
            mExPc = 0; mExInst = NOP_TB; mExRdWren = 0; mExValid = 0;
            mState = 0; mCnt = 0; mDead = 0; mBub = 0;
        end else begin
            if (br || flush) begin
                mExPc = 0; mExInst = NOP_TB; mExRdWren = 0; mExValid = 0;
`ifdef PIPE_PERF_CNT_EN
                if (mBub != 32'hFFFF_FFFF) mBub = mBub + 1;
`endif
            end else begin
                mExPc = mIdPc; mExInst = mIdInst; mExRdWren = rdWren; mExValid = mIdValid;
            end
            if (br) begin
                mIdPc = 0; mIdInst = NOP_TB; mIdValid = 0;
            end else if (!stall) begin
                mIdPc = pc; mIdInst = inst; mIdValid = 1;
            end
            if (br) begin
                mState = 2; mCnt = 0;
            end else if (stall) begin
                mState = 1;
                if (mCnt < LIMIT) mCnt = mCnt + 1;
                if (mCnt >= LIMIT) mDead = 1;
            end else begin
                mState = 0; mCnt = 0;
            end
        end

        e.idPc = mIdPc; e.idInst = mIdInst; e.idValid = mIdValid;
        e.exPc = mExPc; e.exInst = mExInst; e.exRdWren = mExRdWren; e.exValid = mExValid;
        e.state = mState; e.deadlock = mDead; e.bubble = mBub;
        expQ.push_back(e);

        @(posedge i_clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [31:0] expBubble;
        @(negedge i_clk);

        // Reset state
        applyStimulus("rst0", 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        applyStimulus("rst1", 1, 1, 1, 1, 1, 32'h100, 32'hDEAD_BEEF, 1);
        checkField("rst.state",  o_state,      32'd0);
        checkField("rst.bubble", o_bubble_cnt, 32'd0);

        // Free-running fetch
        applyStimulus("f0", 0, 1, 0, 0, 0, 32'h0, 32'h0010_0093, 1);
        applyStimulus("f1", 0, 1, 0, 0, 0, 32'h4, 32'h0020_0113, 1);
        checkField("fetch.EX_pc",    o_EX_pc,      32'h0);
        checkField("fetch.EX_valid", o_EX_valid,   32'd1);
        checkField("fetch.bubble",   o_bubble_cnt, 32'd0);
        applyStimulus("f2", 0, 1, 0, 0, 0, 32'h8, 32'h0030_0193, 0);

        // Stall plus flush for two cycles
        applyStimulus("sf0", 0, 0, 1, 1, 0, 32'hC, 32'h0040_0213, 1);
        applyStimulus("sf1", 0, 0, 1, 1, 0, 32'hC, 32'h0040_0213, 1);
`ifdef PIPE_PERF_CNT_EN
        expBubble = 32'd2;
`else
        expBubble = 32'd0;
`endif
        checkField("sf.ID_inst", o_ID_inst,    32'h0030_0193);
        checkField("sf.EX_inst", o_EX_inst,    NOP_TB);
        checkField("sf.state",   o_state,      32'd1);
        checkField("sf.bubble",  o_bubble_cnt, expBubble);
        applyStimulus("run0", 0, 1, 0, 0, 0, 32'hC, 32'h0040_0213, 1);

        // Branch together with a stall
        applyStimulus("brst", 0, 0, 1, 0, 1, 32'h10, 32'h0050_0293, 1);
        checkField("brst.ID_valid", o_ID_valid, 32'd0);
        checkField("brst.EX_valid", o_EX_valid, 32'd0);
        checkField("brst.state",    o_state,    32'd2);
        applyStimulus("brrun", 0, 1, 0, 0, 0, 32'h40, 32'h0060_0313, 0);
        checkField("brrun.state", o_state, 32'd0);

        // Long stall trips the watchdog
        for (int i = 0; i < 5; i++) begin
            applyStimulus("stall", 0, 0, 1, 0, 0, 32'h44, 32'h0070_0393, 1);
            checkField($sformatf("stall%0d.deadlock", i), o_deadlock, (i >= 3) ? 32'd1 : 32'd0);
        end
        applyStimulus("strel", 0, 1, 0, 0, 0, 32'h44, 32'h0070_0393, 1);
        checkField("strel.deadlock", o_deadlock, 32'd1);

        // Short random mix
        for (int k = 0; k < 24; k++) begin
            applyStimulus("rnd", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                          $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stall
        applyStimulus("pre0", 0, 0, 1, 0, 0, 32'h80, 32'h0080_0413, 1);
        applyStimulus("pre1", 0, 0, 1, 1, 0, 32'h80, 32'h0080_0413, 1);
        applyStimulus("rstmid", 1, 0, 1, 1, 1, 32'h84, 32'h0090_0493, 1);
        checkField("rstmid.state",    o_state,      32'd0);
        checkField("rstmid.deadlock", o_deadlock,   32'd0);
        checkField("rstmid.EX_inst",  o_EX_inst,    NOP_TB);
        checkField("rstmid.bubble",   o_bubble_cnt, 32'd0);
        applyStimulus("post", 0, 1, 0, 0, 0, 32'h200, 32'h00A0_0513, 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
